shift_unit_pipe: RTL and testbench



---
 rtl/shift_unit_pipe.sv | 137 +++++++++++++
 tb/tb_shift_unit_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined RV32I shift unit (SLL/SRL/SRA) with valid/ready on both sides.
// Right shifts reuse the left barrel shifter by bit-reversing operand and result.

module barrel_left32 (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] data_o
);

  logic [31:0] stage;

  // Five mux levels, one per shamt bit (1, 2, 4, 8, 16).
  always_comb begin
    stage = data_i;
    for (int unsigned k = 0; k < 5; k++) begin
      if (shamt_i[k]) stage = stage << (32'd1 << k);
    end
    data_o = stage;
  end

endmodule

module shift_unit_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [31:0]      opa_i,
  input  logic [4:0]       shamt_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o
);

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  logic [31:0]      pre_q,   pre_d;
  logic [4:0]       shamt_q, shamt_d;
  logic             right_q, right_d;
  logic             fill_q,  fill_d;
  logic [TAG_W-1:0] tag1_q,  tag1_d;
  logic             s1_valid_q, s1_valid_d;

  logic [31:0]      result_q, result_d;
  logic [TAG_W-1:0] tag2_q,   tag2_d;
  logic             out_valid_q, out_valid_d;

  logic             in_xfer, out_xfer, adv2;
  logic [31:0]      sh, res;

  assign adv2       = s1_valid_q && (!out_valid_q || out_ready_i);
  assign in_ready_o = !s1_valid_q || adv2;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_q && out_ready_i;

  barrel_left32 u_barrel (
    .data_i  (pre_q),
    .shamt_i (shamt_q),
    .data_o  (sh)
  );

  // Arithmetic fill sets the top shamt bits; a mask of zero when shamt is 0.
  always_comb begin
    res = right_q ? bitrev(sh) : sh;
    if (fill_q) res = res | ~(32'hFFFF_FFFF >> shamt_q);
  end

  always_comb begin
    pre_d      = pre_q;
    shamt_d    = shamt_q;
    right_d    = right_q;
    fill_d     = fill_q;
    tag1_d     = tag1_q;
    s1_valid_d = s1_valid_q;
    if (in_xfer) begin
      pre_d      = op_i[0] ? bitrev(opa_i) : opa_i;
      shamt_d    = shamt_i;
      right_d    = op_i[0];
      fill_d     = (op_i == 2'b11) && opa_i[31];
      tag1_d     = tag_i;
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    result_d    = result_q;
    tag2_d      = tag2_q;
    out_valid_d = out_valid_q;
    if (adv2) begin
      result_d    = res;
      tag2_d      = tag1_q;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_q       <= '0;
      shamt_q     <= '0;
      right_q     <= 1'b0;
      fill_q      <= 1'b0;
      tag1_q      <= '0;
      s1_valid_q  <= 1'b0;
      result_q    <= '0;
      tag2_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      shamt_q     <= shamt_d;
      right_q     <= right_d;
      fill_q      <= fill_d;
      tag1_q      <= tag1_d;
      s1_valid_q  <= s1_valid_d;
      result_q    <= result_d;
      tag2_q      <= tag2_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result_o    = result_q;
  assign tag_o       = tag2_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed-vector bench for shift_unit_pipe: latency, throughput, backpressure and async reset.

module tb_shift_unit_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [4:0]  shamt;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  tag_out;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  vop  [8];
  logic [31:0] vopa [8];
  logic [4:0]  vsh  [8];
  logic [31:0] vexp [8];

  shift_unit_pipe #(.TAG_W(4)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .opa_i       (opa),
    .shamt_i     (shamt),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a,
                       input logic [4:0] s, input logic [3:0] t);
    in_valid = v;
    op       = o;
    opa      = a;
    shamt    = s;
    tag_in   = t;
  endtask

  task automatic run_burst(input string name, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check({name, "/valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "/res"}, result, vexp[i-2]);
        check({name, "/tag"}, {28'd0, tag_out}, 32'(i - 2));
      end
      if (i < n) begin
        check({name, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        drive(1'b1, vop[i], vopa[i], vsh[i], 4'(i));
      end else begin
        drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
      end
    end
    @(negedge clk);
    check({name, "/drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/tag", {28'd0, tag_out}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);

    // Single SLL, latency
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd31, 4'd3);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
    check("lat/not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat/valid", {31'd0, out_valid}, 32'd1);
    check("lat/res", result, 32'h8000_0000);
    check("lat/tag", {28'd0, tag_out}, 32'd3);
    @(negedge clk);
    check("lat/gone", {31'd0, out_valid}, 32'd0);

    // Back-to-back right shifts, including sign fill boundaries
    vop[0] = 2'b01; vopa[0] = 32'h8000_0000; vsh[0] = 5'd4;  vexp[0] = 32'h0800_0000;
    vop[1] = 2'b11; vopa[1] = 32'h8000_0000; vsh[1] = 5'd4;  vexp[1] = 32'hF800_0000;
    vop[2] = 2'b11; vopa[2] = 32'h7FFF_FFF0; vsh[2] = 5'd4;  vexp[2] = 32'h07FF_FFFF;
    vop[3] = 2'b11; vopa[3] = 32'hFFFF_FFFF; vsh[3] = 5'd31; vexp[3] = 32'hFFFF_FFFF;
    vop[4] = 2'b11; vopa[4] = 32'h8000_0000; vsh[4] = 5'd31; vexp[4] = 32'hFFFF_FFFF;
    vop[5] = 2'b01; vopa[5] = 32'hF000_0000; vsh[5] = 5'd28; vexp[5] = 32'h0000_000F;
    vop[6] = 2'b00; vopa[6] = 32'h1234_5678; vsh[6] = 5'd4;  vexp[6] = 32'h2345_6780;
    vop[7] = 2'b01; vopa[7] = 32'h8000_0000; vsh[7] = 5'd31; vexp[7] = 32'h0000_0001;
    run_burst("b2b", 8);

    // Shift by zero for every op, then the reserved encoding
    vop[0] = 2'b00; vopa[0] = 32'hDEAD_BEEF; vsh[0] = 5'd0; vexp[0] = 32'hDEAD_BEEF;
    vop[1] = 2'b01; vopa[1] = 32'hDEAD_BEEF; vsh[1] = 5'd0; vexp[1] = 32'hDEAD_BEEF;
    vop[2] = 2'b11; vopa[2] = 32'hDEAD_BEEF; vsh[2] = 5'd0; vexp[2] = 32'hDEAD_BEEF;
    vop[3] = 2'b10; vopa[3] = 32'hDEAD_BEEF; vsh[3] = 5'd8; vexp[3] = 32'hADBE_EF00;
    run_burst("zero", 4);

    // Backpressure: two accepted, third refused, output held
    out_ready = 1'b0;
    @(negedge clk);
    check("bp/rdy_a", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'b00, 32'h0000_000A, 5'd1, 4'd1);
    @(negedge clk);
    check("bp/rdy_b", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'b01, 32'h0000_0100, 5'd4, 4'd2);
    @(negedge clk);
    drive(1'b1, 2'b11, 32'hF000_0000, 5'd4, 4'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp/rdy_c", {31'd0, in_ready}, 32'd0);
      check("bp/hold_v", {31'd0, out_valid}, 32'd1);
      check("bp/hold_res", result, 32'h0000_0014);
      check("bp/hold_tag", {28'd0, tag_out}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp/rdy_rel", {31'd0, in_ready}, 32'd1);
    check("bp/res_a", result, 32'h0000_0014);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
    check("bp/res_b", result, 32'h0000_0010);
    check("bp/tag_b", {28'd0, tag_out}, 32'd2);
    @(negedge clk);
    check("bp/res_c", result, 32'hFF00_0000);
    check("bp/tag_c", {28'd0, tag_out}, 32'd3);
    @(negedge clk);
    check("bp/no_dup", {31'd0, out_valid}, 32'd0);

    // Simultaneous in/out transfer with both stages full
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd4, 4'd4);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd5, 4'd5);
    @(negedge clk);
    check("sim/full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd6, 4'd6);
    out_ready = 1'b1;
    #1;
    check("sim/rdy", {31'd0, in_ready}, 32'd1);
    check("sim/res_d", result, 32'h0000_0010);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
    out_ready = 1'b0;
    #1;
    check("sim/still_full", {31'd0, in_ready}, 32'd0);
    check("sim/res_e", result, 32'h0000_0020);
    check("sim/tag_e", {28'd0, tag_out}, 32'd5);
    out_ready = 1'b1;
    @(negedge clk);
    check("sim/res_f", result, 32'h0000_0040);
    check("sim/tag_f", {28'd0, tag_out}, 32'd6);
    @(negedge clk);
    check("sim/drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h8000_0000, 5'd1, 4'd7);
    @(negedge clk);
    drive(1'b1, 2'b01, 32'h0000_FF00, 5'd8, 4'd8);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
    check("ar/pre_v", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("ar/valid", {31'd0, out_valid}, 32'd0);
    check("ar/res", result, 32'd0);
    check("ar/tag", {28'd0, tag_out}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar/no_stale", {31'd0, out_valid}, 32'd0);
    end
    check("ar/rdy", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'b00, 32'h0000_0003, 5'd2, 4'd9);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 5'd0, 4'd0);
    @(negedge clk);
    check("ar/new_v", {31'd0, out_valid}, 32'd1);
    check("ar/new_res", result, 32'h0000_000C);
    check("ar/new_tag", {28'd0, tag_out}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
